// File: rtl/eq_comp_checker.sv
// Self-test sequencer for a 4-bit equality comparator: sweeps all 256 A/B pairs,
// counts mismatches against eq_in and captures the first failing vector.
module eq_comp_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  input  logic       eq_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_a,
  output logic [3:0] fail_b
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 9;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [ERR_W-1:0] r_err, w_err;
  logic             r_fail_valid, w_fail_valid;
  logic [3:0]       r_fail_a, w_fail_a;
  logic [3:0]       r_fail_b, w_fail_b;
  logic             w_expected;
  logic             w_mismatch;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt;
      r_err        <= w_err;
      r_fail_valid <= w_fail_valid;
      r_fail_a     <= w_fail_a;
      r_fail_b     <= w_fail_b;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_cnt        = r_cnt;
    w_err        = r_err;
    w_fail_valid = r_fail_valid;
    w_fail_a     = r_fail_a;
    w_fail_b     = r_fail_b;
    w_expected   = (r_idx[7:4] == r_idx[3:0]);
    w_mismatch   = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state      = S_SETTLE;
          w_idx        = '0;
          w_cnt        = '0;
          w_err        = '0;
          w_fail_valid = 1'b0;
          w_fail_a     = '0;
          w_fail_b     = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state = S_CHECK;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        w_mismatch = (eq_in != w_expected);
        if (w_mismatch) begin
          w_err = r_err + ERR_W'(1);
          // Only the first failing vector of a sweep is captured
          if (!r_fail_valid) begin
            w_fail_valid = 1'b1;
            w_fail_a     = r_idx[7:4];
            w_fail_b     = r_idx[3:0];
          end
        end
        if (r_idx == IDX_LAST) begin
          w_state = S_DONE;
        end else begin
          w_idx   = r_idx + IDX_W'(1);
          w_cnt   = '0;
          w_state = S_SETTLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign a_out      = r_idx[7:4];
  assign b_out      = r_idx[3:0];
  assign busy       = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done       = (r_state == S_DONE);
  assign pass       = (r_state == S_DONE) && (r_err == '0);
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_a     = r_fail_a;
  assign fail_b     = r_fail_b;

endmodule

// File: tb/tb_eq_comp_checker.sv
// Directed bench for eq_comp_checker: SETTLE=1 and SETTLE=3 instances driven by
// a selectable comparator model (correct, stuck-0, stuck-1, inverted).
module tb_eq_comp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic [1:0] mode1, mode3;
  logic [3:0] a1, b1, a3, b3;
  logic       eq1, eq3;
  logic       busy1, done1, pass1, fv1;
  logic       busy3, done3, pass3, fv3;
  logic [8:0] err1, err3;
  logic [3:0] fa1, fb1, fa3, fb3;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  // Comparator under test: 0 correct, 1 stuck at 0, 2 stuck at 1, 3 inverted
  function automatic logic cmp_model(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
    case (m)
      2'd0:    return (a == b);
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return (a != b);
    endcase
  endfunction

  always_comb eq1 = cmp_model(mode1, a1, b1);
  always_comb eq3 = cmp_model(mode3, a3, b3);

  eq_comp_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .eq_in(eq1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
  );

  eq_comp_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3), .eq_in(eq3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts edges after the start edge until done; returns -1 if the budget expires
  task automatic wait_done(input int sel, input int n0, output int cnt);
    cnt = n0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      cnt++;
      if ((sel == 1) ? done1 : done3) return;
    end
    cnt = -1;
  endtask

  task automatic run_sweep1(input logic [1:0] m);
    mode1  = m;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_done(1, 0, n);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; mode1 = 2'd0; mode3 = 2'd0;
    tick(); tick();
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_done",  32'(done1), 32'd0);
    chk("rst_pass",  32'(pass1), 32'd0);
    chk("rst_ab",    32'({a1, b1}), 32'd0);
    chk("rst_err",   32'(err1), 32'd0);
    chk("rst_fv",    32'(fv1), 32'd0);
    chk("rst3_busy", 32'(busy3), 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_busy", 32'(busy1), 32'd0);
    chk("idle_done", 32'(done1), 32'd0);

    // Correct comparator, single start pulse
    run_sweep1(2'd0);
    chk("ok_edge", 32'(n), 32'd512);
    chk("ok_pass", 32'(pass1), 32'd1);
    chk("ok_err",  32'(err1), 32'd0);
    chk("ok_fv",   32'(fv1), 32'd0);
    chk("ok_busy", 32'(busy1), 32'd0);
    tick(); tick(); tick();
    chk("ok_done_hold", 32'(done1), 32'd1);
    chk("ok_idx_last",  32'({a1, b1}), 32'd255);

    // Stuck-at-0: every equal pair mismatches, first at 0/0
    run_sweep1(2'd1);
    chk("s0_edge", 32'(n), 32'd512);
    chk("s0_err",  32'(err1), 32'd16);
    chk("s0_pass", 32'(pass1), 32'd0);
    chk("s0_fv",   32'(fv1), 32'd1);
    chk("s0_fa",   32'(fa1), 32'd0);
    chk("s0_fb",   32'(fb1), 32'd0);

    // Stuck-at-1: every unequal pair mismatches, first at 0/1
    run_sweep1(2'd2);
    chk("s1_err",  32'(err1), 32'd240);
    chk("s1_fa",   32'(fa1), 32'd0);
    chk("s1_fb",   32'(fb1), 32'd1);
    chk("s1_pass", 32'(pass1), 32'd0);

    // Inverted comparator: all 256 vectors mismatch
    run_sweep1(2'd3);
    chk("inv_err",  32'(err1), 32'd256);
    chk("inv_pass", 32'(pass1), 32'd0);
    chk("inv_fa",   32'(fa1), 32'd0);
    chk("inv_fb",   32'(fb1), 32'd0);

    // Mid-sweep reset at idx=100 with a start pulse while busy that must be ignored
    mode1  = 2'd1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (49) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (151) tick();
    chk("mid_busy", 32'(busy1), 32'd1);
    chk("mid_idx",  32'({a1, b1}), 32'd100);
    chk("mid_err",  32'(err1), 32'd6);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_ab",   32'({a1, b1}), 32'd0);
    chk("arst_err",  32'(err1), 32'd0);
    chk("arst_fv",   32'({fv1, fa1, fb1}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'({busy1, done1, pass1}), 32'd0);
    run_sweep1(2'd0);
    chk("rerun_edge", 32'(n), 32'd512);
    chk("rerun_pass", 32'(pass1), 32'd1);

    // Start held high: done lasts exactly one cycle before a new sweep
    start1 = 1'b1;
    tick();
    wait_done(1, 0, n);
    chk("hold_edge", 32'(n), 32'd512);
    tick();
    chk("hold_done_drop", 32'(done1), 32'd0);
    chk("hold_busy",      32'(busy1), 32'd1);
    chk("hold_idx",       32'({a1, b1}), 32'd0);
    start1 = 1'b0;

    // SETTLE=3: each vector held 4 cycles, done at edge 1024
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("s3_idx_t%0d", t), 32'({a3, b3}), 32'(t / 4));
    end
    wait_done(3, 12, n);
    chk("s3_edge", 32'(n), 32'd1024);
    chk("s3_pass", 32'(pass3), 32'd1);
    chk("s3_err",  32'(err3), 32'd0);
    chk("s3_fv",   32'(fv3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eq_comp_checker.md
EQ_COMP_CHECKER -- requirements
Module: eq_comp_checker

Interface
REQ-001 SHALL have parameter: SETTLE, default 1, number of clock cycles each vector is held before eq_in is sampled (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  begin a sweep; sampled on rising clk.
REQ-005 SHALL have port: a_out  output  4  operand A driven to comparator under test.
REQ-006 SHALL have port: b_out  output  4  operand B driven to comparator under test.
REQ-007 SHALL have port: eq_in  input  1  Equal result returned by comparator under test.
REQ-008 SHALL have port: busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port: done  output  1  high once a sweep has completed, held until next start or reset.
REQ-010 SHALL have port: pass  output  1  high with done when err_count is zero.
REQ-011 SHALL have port: err_count  output  9  number of mismatching vectors in current/last sweep (0..256).
REQ-012 SHALL have port: fail_valid  output  1  high once at least one mismatch has been captured.
REQ-013 SHALL have port: fail_a  output  4  A value of first mismatching vector.
REQ-014 SHALL have port: fail_b  output  4  B value of first mismatching vector.

Function
REQ-015 SHALL implement states IDLE, SETTLE, CHECK, DONE with an 8-bit vector index idx and a 4-bit settle counter.
REQ-016 SHALL drive a_out = idx[7:4] and b_out = idx[3:0] combinationally from idx in every state.
REQ-017 SHALL, in IDLE or DONE with start high, clear idx, settle counter, err_count, fail_valid, fail_a, fail_b and enter SETTLE.
REQ-018 SHALL ignore start while in SETTLE or CHECK.
REQ-019 SHALL stay in SETTLE for exactly SETTLE cycles (counter 0..SETTLE-1), then enter CHECK.
REQ-020 SHALL, in CHECK, compute expected = (idx[7:4] == idx[3:0]) and flag a mismatch when eq_in != expected.
REQ-021 SHALL, on mismatch, increment err_count by 1; no saturation is needed since 256 is the maximum.
REQ-022 SHALL, on the first mismatch of a sweep only, set fail_valid and load fail_a/fail_b with the current a_out/b_out; later mismatches leave them unchanged.
REQ-023 SHALL, in CHECK with idx < 255, increment idx, clear the settle counter and return to SETTLE.
REQ-024 SHALL, in CHECK with idx == 255, enter DONE with idx remaining 255 (no wrap).
REQ-025 SHALL assert busy exactly in SETTLE and CHECK, and done exactly in DONE.
REQ-026 SHALL assert pass only in DONE and only when err_count == 0.
REQ-027 SHALL check vector k at the (k*(SETTLE+1) + SETTLE + 1)-th rising edge after the edge sampling start; with SETTLE=1 done rises 512 cycles after that edge.
REQ-028 SHALL, with start held high continuously, begin a new sweep on the cycle after reaching DONE (done high one cycle).

Reset
REQ-029 SHALL, on rst high at any time including mid-sweep, immediately force state IDLE, idx 0, settle counter 0, err_count 0, fail_valid 0, fail_a 0, fail_b 0.
REQ-030 SHALL hold busy, done, pass low, and a_out, b_out at 0, while in reset and after release until start.
REQ-031 SHALL resume normal operation on the first rising clk after rst deasserts.

Verification
REQ-032 SHALL verify: correct comparator model on eq_in, start pulse, SETTLE=1 -> done at edge 512, pass=1, err_count=0, fail_valid=0.
REQ-033 SHALL verify: eq_in stuck at 0 -> err_count=16, pass=0, fail_valid=1, fail_a=0, fail_b=0.
REQ-034 SHALL verify: eq_in stuck at 1 -> err_count=240, fail_a=0, fail_b=1.
REQ-035 SHALL verify: eq_in inverted comparator -> err_count=256, pass=0, fail_a=0, fail_b=0.
REQ-036 SHALL verify: rst pulsed at idx=100 mid-sweep -> all outputs 0 and state IDLE immediately; start ignored while busy; a fresh start re-runs the full sweep to pass=1.
REQ-037 SHALL verify: SETTLE=3, correct model -> done at edge 1024, a_out/b_out stable for 4 cycles per vector, pass=1.
